// File: rtl/alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_scheduler
// Purpose  : Shares four registered ALU execution units (arith, logic, cmp,
//            shift) between two requesters. Round-robin arbitration, one-cycle
//            one-hot unit enable, mandatory result capture in the following
//            cycle, and a valid/ready result port with back-pressure.
// Ports    :
//   CLK, RST                        clock (rising edge), async active-low reset
//   REQx_VALID/READY/A/B/FUNC       requester ports, FUNC[3:2] unit, [1:0] op
//   ALU_A, ALU_B, ALU_FUNC          shared operand/function bus to the units
//   ARITH/LOGIC/CMP/SHIFT_EN        unit enables (one-hot or all zero)
//   ARITH/LOGIC/CMP/SHIFT_OUT/FLAG  registered unit results and valid flags
//   RES_VALID/READY/DATA/ID/ERR     result port
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_scheduler #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0_VALID,
  output logic                 REQ0_READY,
  input  logic [A_WIDTH-1:0]   REQ0_A,
  input  logic [B_WIDTH-1:0]   REQ0_B,
  input  logic [3:0]           REQ0_FUNC,
  input  logic                 REQ1_VALID,
  output logic                 REQ1_READY,
  input  logic [A_WIDTH-1:0]   REQ1_A,
  input  logic [B_WIDTH-1:0]   REQ1_B,
  input  logic [3:0]           REQ1_FUNC,
  output logic [A_WIDTH-1:0]   ALU_A,
  output logic [B_WIDTH-1:0]   ALU_B,
  output logic [1:0]           ALU_FUNC,
  output logic                 ARITH_EN,
  output logic                 LOGIC_EN,
  output logic                 CMP_EN,
  output logic                 SHIFT_EN,
  input  logic [OUT_WIDTH-1:0] ARITH_OUT,
  input  logic [OUT_WIDTH-1:0] LOGIC_OUT,
  input  logic [OUT_WIDTH-1:0] CMP_OUT,
  input  logic [OUT_WIDTH-1:0] SHIFT_OUT,
  input  logic                 ARITH_FLAG,
  input  logic                 LOGIC_FLAG,
  input  logic                 CMP_FLAG,
  input  logic                 SHIFT_FLAG,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [OUT_WIDTH-1:0] RES_DATA,
  output logic                 RES_ID,
  output logic                 RES_ERR
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [1:0] c_UNIT_ARITH = 2'b00;
  localparam logic [1:0] c_UNIT_LOGIC = 2'b01;
  localparam logic [1:0] c_UNIT_CMP   = 2'b10;
  localparam logic [1:0] c_UNIT_SHIFT = 2'b11;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_last_gnt;
  logic [A_WIDTH-1:0]   r_a;
  logic [B_WIDTH-1:0]   r_b;
  logic [3:0]           r_func;
  logic                 r_id;
  logic [OUT_WIDTH-1:0] r_res_data;
  logic                 r_res_id;
  logic                 r_res_err;

  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_accept;
  logic [OUT_WIDTH-1:0] w_sel_out;
  logic                 w_sel_flag;

  // Round-robin: a lone requester always wins; on a tie the requester that
  // was not granted last wins.
  assign w_gnt0 = REQ0_VALID & (~REQ1_VALID | r_last_gnt);
  assign w_gnt1 = REQ1_VALID & (~REQ0_VALID | ~r_last_gnt);

  // READY is gated by RST so it stays low while reset is asserted even
  // though the state register already reads IDLE.
  assign REQ0_READY = RST & (r_state == IDLE) & w_gnt0;
  assign REQ1_READY = RST & (r_state == IDLE) & w_gnt1;

  // A grant implies VALID, so either READY marks a completed handshake.
  assign w_accept = REQ0_READY | REQ1_READY;

  // Next state plus the unit-side bus, which is only non-zero in ISSUE.
  always_comb begin
    w_next_state = r_state;
    ALU_A        = '0;
    ALU_B        = '0;
    ALU_FUNC     = 2'b00;
    ARITH_EN     = 1'b0;
    LOGIC_EN     = 1'b0;
    CMP_EN       = 1'b0;
    SHIFT_EN     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = ISSUE;
      end
      ISSUE: begin
        ALU_A    = r_a;
        ALU_B    = r_b;
        ALU_FUNC = r_func[1:0];
        case (r_func[3:2])
          c_UNIT_ARITH: ARITH_EN = 1'b1;
          c_UNIT_LOGIC: LOGIC_EN = 1'b1;
          c_UNIT_CMP:   CMP_EN   = 1'b1;
          default:      SHIFT_EN = 1'b1;
        endcase
        w_next_state = CAPTURE;
      end
      CAPTURE: begin
        w_next_state = HOLD;
      end
      HOLD: begin
        if (RES_READY) w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Result/flag of the unit chosen by the latched FUNC.
  always_comb begin
    w_sel_out  = SHIFT_OUT;
    w_sel_flag = SHIFT_FLAG;
    case (r_func[3:2])
      c_UNIT_ARITH: begin w_sel_out = ARITH_OUT; w_sel_flag = ARITH_FLAG; end
      c_UNIT_LOGIC: begin w_sel_out = LOGIC_OUT; w_sel_flag = LOGIC_FLAG; end
      c_UNIT_CMP:   begin w_sel_out = CMP_OUT;   w_sel_flag = CMP_FLAG;   end
      c_UNIT_SHIFT: begin w_sel_out = SHIFT_OUT; w_sel_flag = SHIFT_FLAG; end
      default:      begin w_sel_out = SHIFT_OUT; w_sel_flag = SHIFT_FLAG; end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_a        <= '0;
      r_b        <= '0;
      r_func     <= 4'h0;
      r_id       <= 1'b0;
      r_res_data <= '0;
      r_res_id   <= 1'b0;
      r_res_err  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a        <= REQ1_READY ? REQ1_A    : REQ0_A;
        r_b        <= REQ1_READY ? REQ1_B    : REQ0_B;
        r_func     <= REQ1_READY ? REQ1_FUNC : REQ0_FUNC;
        r_id       <= REQ1_READY;
        r_last_gnt <= REQ1_READY;
      end
      // Units clear their outputs once their enable drops, so the result is
      // only present during CAPTURE and must be taken here.
      if (r_state == CAPTURE) begin
        r_res_data <= w_sel_out;
        r_res_err  <= ~w_sel_flag;
        r_res_id   <= r_id;
      end
    end
  end

  assign RES_VALID = (r_state == HOLD);
  assign RES_DATA  = r_res_data;
  assign RES_ID    = r_res_id;
  assign RES_ERR   = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_scheduler
// Purpose  : Self-checking bench for alu_op_scheduler with behavioural
//            registered ALU unit models and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic        REQ0_READY, REQ1_READY;
  logic [7:0]  REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
  logic [3:0]  REQ0_FUNC = '0, REQ1_FUNC = '0;
  logic [7:0]  ALU_A, ALU_B;
  logic [1:0]  ALU_FUNC;
  logic        ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN;
  logic [15:0] ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT;
  logic        ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic [15:0] RES_DATA;
  logic        RES_ID, RES_ERR;

  bit          kill_cmp = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        id;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [3:0]  exp_en    = '0;
  logic [17:0] exp_ops   = '0;
  bit          prev_hold = 1'b0;
  logic [17:0] prev_res  = '0;
  int          hs_count  = 0;
  int          en_pulses = 0;

  alu_op_scheduler #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUNC(REQ0_FUNC),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUNC(REQ1_FUNC),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC),
    .ARITH_EN(ARITH_EN), .LOGIC_EN(LOGIC_EN), .CMP_EN(CMP_EN), .SHIFT_EN(SHIFT_EN),
    .ARITH_OUT(ARITH_OUT), .LOGIC_OUT(LOGIC_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .ARITH_FLAG(ARITH_FLAG), .LOGIC_FLAG(LOGIC_FLAG), .CMP_FLAG(CMP_FLAG), .SHIFT_FLAG(SHIFT_FLAG),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_ID(RES_ID), .RES_ERR(RES_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference behaviour of the four units, indexed by the full 4-bit FUNC.
  function automatic logic [15:0] calc(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb;
    ea = {8'h00, a};
    eb = {8'h00, b};
    case (f)
      4'b0000: return ea + eb;
      4'b0001: return ea - eb;
      4'b0010: return ea * eb;
      4'b0011: return ea + 16'd1;
      4'b0100: return ea & eb;
      4'b0101: return ea | eb;
      4'b0110: return ea ^ eb;
      4'b0111: return {8'h00, ~a};
      4'b1000: return {15'd0, a < b};
      4'b1001: return {15'd0, a == b};
      4'b1010: return {15'd0, a > b};
      4'b1011: return (a > b) ? ea : eb;
      4'b1100: return ea << b[2:0];
      4'b1101: return ea << 1;
      4'b1110: return ea >> b[2:0];
      default: return ea >> 1;
    endcase
  endfunction

  // Registered unit models: result and flag only in the cycle after enable.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ARITH_OUT <= '0; LOGIC_OUT <= '0; CMP_OUT <= '0; SHIFT_OUT <= '0;
      ARITH_FLAG <= 1'b0; LOGIC_FLAG <= 1'b0; CMP_FLAG <= 1'b0; SHIFT_FLAG <= 1'b0;
    end else begin
      ARITH_OUT  <= ARITH_EN ? calc({2'b00, ALU_FUNC}, ALU_A, ALU_B) : 16'h0;
      LOGIC_OUT  <= LOGIC_EN ? calc({2'b01, ALU_FUNC}, ALU_A, ALU_B) : 16'h0;
      CMP_OUT    <= CMP_EN   ? calc({2'b10, ALU_FUNC}, ALU_A, ALU_B) : 16'h0;
      SHIFT_OUT  <= SHIFT_EN ? calc({2'b11, ALU_FUNC}, ALU_A, ALU_B) : 16'h0;
      ARITH_FLAG <= ARITH_EN;
      LOGIC_FLAG <= LOGIC_EN;
      CMP_FLAG   <= CMP_EN & ~kill_cmp;
      SHIFT_FLAG <= SHIFT_EN;
    end
  end

  // Monitor: samples 2 time units before each rising edge; inputs change only
  // at falling edges (reset may also drop 2 units after one).
  always @(negedge CLK) begin
    exp_t e;
    #3;
    if (!RST) begin
      exp_en = '0; exp_ops = '0; prev_hold = 1'b0;
      sb.delete();
    end else begin
      n_tests++;
      if ({ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN} !== exp_en) begin
        n_fail++;
        $display("FAIL mon_enables: got %b want %b", {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, exp_en);
      end
      n_tests++;
      if ({ALU_A, ALU_B, ALU_FUNC} !== exp_ops) begin
        n_fail++;
        $display("FAIL mon_alu_bus: got %h want %h", {ALU_A, ALU_B, ALU_FUNC}, exp_ops);
      end
      if (ARITH_EN | LOGIC_EN | CMP_EN | SHIFT_EN) en_pulses++;
      exp_en = '0;
      exp_ops = '0;
      n_tests++;
      if (REQ0_READY === 1'b1 && REQ1_READY === 1'b1) begin
        n_fail++;
        $display("FAIL mon_ready_excl: got both READY high want at most one");
      end
      if (REQ0_VALID === 1'b1 && REQ0_READY === 1'b1) begin
        sb.push_back({calc(REQ0_FUNC, REQ0_A, REQ0_B), 1'b0, kill_cmp && REQ0_FUNC[3:2] == 2'b10});
        exp_en  = 4'b1000 >> REQ0_FUNC[3:2];
        exp_ops = {REQ0_A, REQ0_B, REQ0_FUNC[1:0]};
        hs_count++;
      end else if (REQ1_VALID === 1'b1 && REQ1_READY === 1'b1) begin
        sb.push_back({calc(REQ1_FUNC, REQ1_A, REQ1_B), 1'b1, kill_cmp && REQ1_FUNC[3:2] == 2'b10});
        exp_en  = 4'b1000 >> REQ1_FUNC[3:2];
        exp_ops = {REQ1_A, REQ1_B, REQ1_FUNC[1:0]};
        hs_count++;
      end
      if (prev_hold) begin
        n_tests++;
        if ({RES_VALID, RES_DATA, RES_ID, RES_ERR} !== {1'b1, prev_res}) begin
          n_fail++;
          $display("FAIL mon_hold_stable: got %h want %h", {RES_VALID, RES_DATA, RES_ID, RES_ERR}, {1'b1, prev_res});
        end
      end
      if (RES_VALID === 1'b1) begin
        n_tests++;
        if ((REQ0_READY | REQ1_READY) !== 1'b0) begin
          n_fail++;
          $display("FAIL mon_ready_in_hold: got READY %b%b want 00", REQ1_READY, REQ0_READY);
        end
      end
      if (RES_VALID === 1'b1 && RES_READY === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL mon_unexpected_result: got data %h with empty scoreboard", RES_DATA);
        end else begin
          e = sb.pop_front();
          if ({RES_DATA, RES_ID, RES_ERR} !== e) begin
            n_fail++;
            $display("FAIL mon_result: got data %h id %b err %b want data %h id %b err %b",
                     RES_DATA, RES_ID, RES_ERR, e.data, e.id, e.err);
          end
        end
      end
      prev_hold = (RES_VALID === 1'b1) && (RES_READY !== 1'b1);
      prev_res  = {RES_DATA, RES_ID, RES_ERR};
    end
  end

  task automatic do_reset();
    RST = 1'b0; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RES_READY = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  // Waits (bounded) until the scoreboard is empty and no result is pending.
  task automatic drain();
    int n;
    n = 0;
    @(negedge CLK);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RES_READY = 1'b1;
    #4;
    while (sb.size() != 0 || RES_VALID === 1'b1) begin
      n++;
      if (n > 20) begin
        n_tests++; n_fail++;
        $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        break;
      end
      @(negedge CLK); #4;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    @(negedge CLK);
    REQ0_VALID = 1'b1;
    #4;
    n_tests++;
    if ({REQ0_READY, REQ1_READY, ALU_A, ALU_B, ALU_FUNC, ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN,
         RES_VALID, RES_DATA, RES_ID, RES_ERR} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero output want all zero");
    end
    @(negedge CLK);
    RST = 1'b1; REQ0_VALID = 1'b0;
    #4;
    n_tests++;
    if ({RES_VALID, ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b want 00000", {RES_VALID, ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN});
    end
  endtask

  task automatic test_shift();
    @(negedge CLK);
    RES_READY = 1'b1; REQ0_VALID = 1'b1; REQ0_A = 8'h35; REQ0_B = 8'h00; REQ0_FUNC = 4'b1101;
    #4;
    n_tests++;
    if (REQ0_READY !== 1'b1) begin n_fail++; $display("FAIL shift_ready_t0: got %b want 1", REQ0_READY); end
    @(negedge CLK);
    REQ0_VALID = 1'b0;
    #4;
    n_tests++;
    if ({ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN, ALU_FUNC, ALU_A} !== {4'b0001, 2'b01, 8'h35}) begin
      n_fail++;
      $display("FAIL shift_issue_t1: got en %b func %b a %h want en 0001 func 01 a 35",
               {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, ALU_FUNC, ALU_A);
    end
    @(negedge CLK); #4;
    n_tests++;
    if ({ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN, ALU_A, RES_VALID} !== 13'b0) begin
      n_fail++;
      $display("FAIL shift_capture_t2: got en %b a %h valid %b want all zero",
               {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, ALU_A, RES_VALID);
    end
    @(negedge CLK); #4;
    n_tests++;
    if ({RES_VALID, RES_DATA, RES_ID, RES_ERR} !== {1'b1, 16'h006A, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL shift_result_t3: got valid %b data %h id %b err %b want 1 006a 0 0",
               RES_VALID, RES_DATA, RES_ID, RES_ERR);
    end
    @(negedge CLK); #4;
    n_tests++;
    if (RES_VALID !== 1'b0) begin n_fail++; $display("FAIL shift_valid_drop_t4: got %b want 0", RES_VALID); end
  endtask

  task automatic test_arbitration();
    int  got;
    int  cyc;
    logic a0, a1;
    do_reset();
    @(negedge CLK);
    RES_READY = 1'b1;
    REQ0_VALID = 1'b1; REQ0_A = 8'h10; REQ0_B = 8'h03; REQ0_FUNC = 4'b0000;
    REQ1_VALID = 1'b1; REQ1_A = 8'h20; REQ1_B = 8'h05; REQ1_FUNC = 4'b0101;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 60) begin
      #4;
      a0 = REQ0_READY; a1 = REQ1_READY;
      if (a0 === 1'b1 || a1 === 1'b1) begin
        n_tests++;
        if ({a1, a0} !== ((got % 2 == 1) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL arb_order_%0d: got READY %b%b want grant %0d", got, a1, a0, got % 2);
        end
        got++;
      end
      @(negedge CLK);
      cyc++;
      if (a0 === 1'b1) REQ0_A = REQ0_A + 8'd1;
      if (a1 === 1'b1) REQ1_A = REQ1_A + 8'd1;
    end
    if (got < 4) begin
      n_tests++; n_fail++;
      $display("FAIL arb_timeout: got %0d grants want 4", got);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit          got;
    bit          seen;
    logic [17:0] held;
    @(negedge CLK);
    RES_READY = 1'b0;
    REQ1_VALID = 1'b1; REQ1_A = 8'h12; REQ1_B = 8'h34; REQ1_FUNC = 4'b0000;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #4;
      if (REQ1_READY === 1'b1) got = 1'b1;
      @(negedge CLK);
    end
    REQ1_VALID = 1'b0;
    REQ0_VALID = 1'b1; REQ0_A = 8'h77; REQ0_B = 8'h01; REQ0_FUNC = 4'b0100;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #4;
      if (RES_VALID === 1'b1) begin seen = 1'b1; break; end
      @(negedge CLK);
    end
    n_tests++;
    if (!got || !seen || {RES_DATA, RES_ID, RES_ERR} !== {16'h0046, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_first_result: got hs %b valid %b data %h id %b err %b want 1 1 0046 1 0",
               got, seen, RES_DATA, RES_ID, RES_ERR);
    end
    held = {RES_DATA, RES_ID, RES_ERR};
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK); #4;
      n_tests++;
      if ({RES_VALID, RES_DATA, RES_ID, RES_ERR, REQ0_READY, ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN} !==
          {1'b1, held, 5'b0}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got valid %b res %h ready %b en %b want 1 %h 0 0000", c,
                 RES_VALID, {RES_DATA, RES_ID, RES_ERR}, REQ0_READY, {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, held);
      end
    end
    @(negedge CLK);
    RES_READY = 1'b1;
    #4;
    n_tests++;
    if (RES_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid: got %b want 1", RES_VALID); end
    @(negedge CLK); #4;
    n_tests++;
    if ({RES_VALID, REQ0_READY} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_after_release: got valid %b ready0 %b want 0 1", RES_VALID, REQ0_READY);
    end
    drain();
  endtask

  task automatic test_missing_flag();
    bit          got;
    logic [15:0] cmp_t2;
    @(negedge CLK);
    kill_cmp = 1'b1; RES_READY = 1'b1;
    REQ0_VALID = 1'b1; REQ0_A = 8'h05; REQ0_B = 8'h09; REQ0_FUNC = 4'b1000;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #4;
      if (REQ0_READY === 1'b1) got = 1'b1;
      @(negedge CLK);
    end
    REQ0_VALID = 1'b0;
    #4;
    n_tests++;
    if (!got || CMP_EN !== 1'b1) begin n_fail++; $display("FAIL flag_cmp_en: got hs %b en %b want 1 1", got, CMP_EN); end
    @(negedge CLK); #4;
    cmp_t2 = CMP_OUT;
    n_tests++;
    if ({CMP_OUT, CMP_FLAG} !== {16'h0001, 1'b0}) begin
      n_fail++;
      $display("FAIL flag_unit_t2: got out %h flag %b want 0001 0", CMP_OUT, CMP_FLAG);
    end
    @(negedge CLK); #4;
    n_tests++;
    if ({RES_VALID, RES_DATA, RES_ERR} !== {1'b1, cmp_t2, 1'b1}) begin
      n_fail++;
      $display("FAIL flag_result: got valid %b data %h err %b want 1 %h 1", RES_VALID, RES_DATA, RES_ERR, cmp_t2);
    end
    drain();
    kill_cmp = 1'b0;
  endtask

  task automatic test_reset_midop();
    bit got;
    @(negedge CLK);
    RES_READY = 1'b1;
    REQ0_VALID = 1'b1; REQ0_A = 8'h0F; REQ0_B = 8'h02; REQ0_FUNC = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #4;
      if (REQ0_READY === 1'b1) got = 1'b1;
      @(negedge CLK);
    end
    REQ0_VALID = 1'b0;
    #4;
    @(negedge CLK);
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    n_tests++;
    if ({REQ0_READY, REQ1_READY, ALU_A, ALU_B, ALU_FUNC, ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN,
         RES_VALID, RES_DATA, RES_ID, RES_ERR} !== '0 || !got) begin
      n_fail++;
      $display("FAIL midop_reset_outputs: got hs %b valid %b en %b ready %b%b want hs 1 and all zero", got,
               RES_VALID, {ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, REQ1_READY, REQ0_READY);
    end
    @(negedge CLK); #4;
    n_tests++;
    if ({REQ0_READY, REQ1_READY} !== 2'b00) begin
      n_fail++;
      $display("FAIL midop_ready_in_reset: got %b%b want 00", REQ1_READY, REQ0_READY);
    end
    @(negedge CLK);
    RST = 1'b1; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #4;
      n_tests++;
      if (RES_VALID !== 1'b0) begin n_fail++; $display("FAIL midop_no_result_%0d: got %b want 0", c, RES_VALID); end
      @(negedge CLK);
    end
    REQ0_VALID = 1'b1; REQ0_A = 8'h44; REQ0_B = 8'h11; REQ0_FUNC = 4'b0110;
    REQ1_VALID = 1'b1; REQ1_A = 8'h55; REQ1_B = 8'h22; REQ1_FUNC = 4'b1110;
    #4;
    n_tests++;
    if ({REQ1_READY, REQ0_READY} !== 2'b01) begin
      n_fail++;
      $display("FAIL midop_first_tie: got READY %b%b want 01", REQ1_READY, REQ0_READY);
    end
    drain();
  endtask

  task automatic test_random();
    int   hs0, p0, cyc;
    logic a0, a1;
    hs0 = hs_count; p0 = en_pulses; cyc = 0;
    a0 = 1'b0; a1 = 1'b0;
    while ((hs_count - hs0) < 200 && cyc < 6000) begin
      @(negedge CLK);
      cyc++;
      if (a0) REQ0_VALID = 1'b0;
      else if (REQ0_VALID !== 1'b1 && $urandom_range(1, 0) == 1) begin
        REQ0_VALID = 1'b1; REQ0_A = 8'($urandom); REQ0_B = 8'($urandom); REQ0_FUNC = 4'($urandom);
      end
      if (a1) REQ1_VALID = 1'b0;
      else if (REQ1_VALID !== 1'b1 && $urandom_range(1, 0) == 1) begin
        REQ1_VALID = 1'b1; REQ1_A = 8'($urandom); REQ1_B = 8'($urandom); REQ1_FUNC = 4'($urandom);
      end
      RES_READY = ($urandom_range(3, 0) != 0);
      #4;
      a0 = REQ0_VALID & REQ0_READY;
      a1 = REQ1_VALID & REQ1_READY;
    end
    n_tests++;
    if ((hs_count - hs0) < 200) begin
      n_fail++;
      $display("FAIL rand_timeout: got %0d operations want 200", hs_count - hs0);
    end
    drain();
    n_tests++;
    if ((en_pulses - p0) != (hs_count - hs0)) begin
      n_fail++;
      $display("FAIL rand_pulse_count: got %0d enable cycles want %0d", en_pulses - p0, hs_count - hs0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_shift();
    test_arbitration();
    test_backpressure();
    test_missing_flag();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
